// File: rtl/median3x3_row_engine.sv
// median3x3_row_engine
//   Accepts one 3-row window through a valid/ready handshake. The upstream
//   sequencer has already replicated the edge rows. The engine sweeps the
//   window column by column through a 3-stage 3x3 median network and
//   presents the filtered middle row as one wide word with a valid/ready
//   handshake.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   win_in     {top, mid, bot} rows; pixel i of a row at [i*width +: width]
//   in_valid   win_in valid
//   in_ready   engine can accept a window (IDLE only)
//   row_out    filtered middle row, same packing as one row of win_in
//   out_valid  row_out complete and stable (DONE)
//   out_ready  consumer takes row_out
//   busy       high in SWEEP or DRAIN
//   col        current issue column (debug)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a window; in_ready high once out of reset
// SWEEP | issue one column per cycle into the median pipeline
// DRAIN | two cycles to flush the last column into row_out
// DONE  | row_out complete; out_valid high until out_ready
//
// Timing: the accept edge is edge 0. Column c is issued in the cycle after
// edge c and lands in row_out at edge c+3. The last column lands at edge
// ROW+2, which is also the edge that enters DONE. out_valid is therefore
// first seen high at edge ROW+3, and one window takes ROW+4 cycles at the
// earliest.
module median3x3_row_engine #(
  parameter int ROW   = 512,
  parameter int width = 8,
  parameter int CW    = 9
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [3*ROW*width-1:0] win_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ROW*width-1:0]   row_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [CW-1:0]          col
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(ROW - 1);

  state_t                 state, state_nxt;
  logic                   armed;
  logic [3*ROW*width-1:0] win_r;
  logic [1:0]             drain_cnt;
  logic                   last_col;
  logic                   accept;

  // Returns {max, mid, min}. The compares are unsigned and width bits wide.
  function automatic logic [3*width-1:0] sort3(input logic [width-1:0] a,
                                               input logic [width-1:0] b,
                                               input logic [width-1:0] c);
    logic [width-1:0] x, y, t, lo, md, hi;
    x  = (a < b) ? a : b;
    y  = (a < b) ? b : a;
    lo = (x < c) ? x : c;
    t  = (x < c) ? c : x;
    md = (y < t) ? y : t;
    hi = (y < t) ? t : y;
    return {hi, md, lo};
  endfunction

  // r: 0 = bottom, 1 = middle, 2 = top
  function automatic logic [width-1:0] pix(input logic [3*ROW*width-1:0] w,
                                           input int r,
                                           input logic [CW-1:0] i);
    return w[(r*ROW + int'(i))*width +: width];
  endfunction

  assign last_col = (col == COL_LAST);
  assign accept   = in_ready & in_valid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = armed;
        if (armed && in_valid) state_nxt = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (last_col) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd1) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // armed keeps in_ready low while reset is held and for the rest of that
  // cycle. in_ready then rises on the first edge after release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed     <= 1'b0;
      win_r     <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        win_r <= win_in;
        col   <= '0;
      end
      if (state == SWEEP) begin
        if (last_col) drain_cnt <= '0;
        else          col <= col + CW'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
    end
  end

  // Issue stage: the left and right neighbours are clamped to the row ends.
  logic [CW-1:0]    idx [3];
  logic [width-1:0] s1_lo_d [3];
  logic [width-1:0] s1_md_d [3];
  logic [width-1:0] s1_hi_d [3];

  always_comb begin
    idx[0] = (col == '0) ? '0 : col - CW'(1);
    idx[1] = col;
    idx[2] = last_col ? col : col + CW'(1);
    for (int k = 0; k < 3; k++) begin
      {s1_hi_d[k], s1_md_d[k], s1_lo_d[k]} =
        sort3(pix(win_r, 2, idx[k]), pix(win_r, 1, idx[k]), pix(win_r, 0, idx[k]));
    end
  end

  // S1: each of the three columns sorted.
  logic             s1_v;
  logic [CW-1:0]    s1_col;
  logic [width-1:0] s1_lo [3];
  logic [width-1:0] s1_md [3];
  logic [width-1:0] s1_hi [3];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_v   <= 1'b0;
      s1_col <= '0;
      for (int k = 0; k < 3; k++) begin
        s1_lo[k] <= '0;
        s1_md[k] <= '0;
        s1_hi[k] <= '0;
      end
    end else begin
      s1_v   <= (state == SWEEP);
      s1_col <= col;
      for (int k = 0; k < 3; k++) begin
        s1_lo[k] <= s1_lo_d[k];
        s1_md[k] <= s1_md_d[k];
        s1_hi[k] <= s1_hi_d[k];
      end
    end
  end

  // S2: the 3x3 median is the median of these three values.
  // A = max of the mins, B = median of the mids, C = min of the maxes.
  logic [width-1:0] a_d, b_d, c_d, unused_a0, unused_a1, unused_b0, unused_b1,
                    unused_c0, unused_c1;

  always_comb begin
    {a_d, unused_a1, unused_a0} = sort3(s1_lo[0], s1_lo[1], s1_lo[2]);
    {unused_b1, b_d, unused_b0} = sort3(s1_md[0], s1_md[1], s1_md[2]);
    {unused_c1, unused_c0, c_d} = sort3(s1_hi[0], s1_hi[1], s1_hi[2]);
  end

  logic             s2_v;
  logic [CW-1:0]    s2_col;
  logic [width-1:0] s2_a, s2_b, s2_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_v   <= 1'b0;
      s2_col <= '0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_c   <= '0;
    end else begin
      s2_v   <= s1_v;
      s2_col <= s1_col;
      s2_a   <= a_d;
      s2_b   <= b_d;
      s2_c   <= c_d;
    end
  end

  // S3: write the median into its column slot of row_out.
  logic [width-1:0] med_d, unused_m0, unused_m1;

  always_comb begin
    {unused_m1, med_d, unused_m0} = sort3(s2_a, s2_b, s2_c);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_out <= '0;
    end else if (s2_v) begin
      row_out[int'(s2_col)*width +: width] <= med_d;
    end
  end

endmodule

// File: tb/tb_median3x3_row_engine.sv
// Directed bench for median3x3_row_engine with ROW=8 and width=8.
module tb_median3x3_row_engine;
  localparam int ROW = 8;
  localparam int W   = 8;
  localparam int CW  = 9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3*ROW*W-1:0]   win_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROW*W-1:0]     row_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic [CW-1:0]        col;

  always #5 clk = ~clk;

  median3x3_row_engine #(.ROW(ROW), .width(W), .CW(CW)) dut (
    .CLK(clk), .RST(rst_n), .win_in(win_in), .in_valid(in_valid),
    .in_ready(in_ready), .row_out(row_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .col(col)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full 9-value sort with clamped neighbour columns.
  function automatic logic [63:0] ref_row(input logic [191:0] w);
    logic [63:0] res;
    logic [7:0]  v [9];
    logic [7:0]  tmp;
    int          n, c;
    res = '0;
    for (int i = 0; i < ROW; i++) begin
      n = 0;
      for (int r = 0; r < 3; r++) begin
        for (int d = -1; d <= 1; d++) begin
          c = i + d;
          if (c < 0) c = 0;
          if (c > ROW - 1) c = ROW - 1;
          v[n] = w[r*64 + c*8 +: 8];
          n++;
        end
      end
      for (int p = 0; p < 9; p++) begin
        for (int q = 0; q < 8 - p; q++) begin
          if (v[q] > v[q+1]) begin
            tmp = v[q]; v[q] = v[q+1]; v[q+1] = tmp;
          end
        end
      end
      res[i*8 +: 8] = v[4];
    end
    return res;
  endfunction

  // Accept edge is edge 0. Sampling on the falling edge after edge e shows the
  // value that is seen at edge e+1. Valid must first show up after edge ROW+2,
  // which is the value seen at edge ROW+3. Busy must show up after edges
  // 0..ROW+1.
  task automatic do_window(input logic [191:0] w, input string tag);
    int k, bn, ovk;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    win_in   = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bn  = 0;
    ovk = -1;
    for (int e = 0; e < 40; e++) begin
      if (out_valid) begin
        ovk = e;
        break;
      end
      if (busy) bn++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(ovk), 64'(ROW + 2));
    check({tag, "_busy"}, 64'(bn), 64'(ROW + 2));
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdyback"}, 64'(in_ready), 64'd1);
  endtask

  logic [191:0] wa, wb, wr;
  logic [63:0]  exp_a;
  int           k;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    win_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_inrdy", 64'(in_ready), 64'd0);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_row", row_out, 64'd0);
    check("rst_col", 64'(col), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_inrdy0", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("rel_inrdy1", 64'(in_ready), 64'd1);

    // Flat image.
    do_window({64'h5555555555555555, 64'h5555555555555555, 64'h5555555555555555}, "flat");
    check("flat_row", row_out, 64'h5555555555555555);
    finish_out("flat");

    // Impulse noise on the middle row.
    do_window({64'h0A0A0A0A0A0A0A0A, 64'hC80AC80AC80AC80A, 64'h0A0A0A0A0A0A0A0A}, "imp");
    check("imp_row", row_out, 64'h0A0A0A0A0A0A0A0A);
    finish_out("imp");

    // Ramp: checks clamping at both row ends.
    do_window({64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110}, "ramp");
    check("ramp_row", row_out, 64'h0F0E0D0C0B0A0908);
    finish_out("ramp");

    // FF/00 mix: a signed compare would invert every pixel.
    do_window({64'hFFFFFFFFFFFFFFFF, 64'h00FF00FF00FF00FF, 64'h0000000000000000}, "uns");
    check("uns_row", row_out, 64'h0000FF00FF00FFFF);
    finish_out("uns");

    // Back-to-back windows with a held output.
    wa    = {64'h10F03C7A2299E104, 64'h8833C0015AA5FF7E, 64'h0102030405060708};
    wb    = {64'hA0A1A2A3A4A5A6A7, 64'h1F2E3D4C5B6A7988, 64'h9080706050403020};
    exp_a = ref_row(wa);
    do_window(wa, "bb1");
    win_in   = wb;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_ov", 64'(out_valid), 64'd1);
      check("hold_row", row_out, exp_a);
      check("hold_inrdy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    finish_out("bb1");
    do_window(wb, "bb2");
    check("bb2_row", row_out, ref_row(wb));
    finish_out("bb2");

    // Reset in the middle of a sweep.
    win_in   = wa;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (col != 9'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_col", 64'(col), 64'd4);
    rst_n = 1'b0;
    #1;
    check("abort_ov", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_row", row_out, 64'd0);
    check("abort_inrdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_window(wr, "post");
    check("post_row", row_out, ref_row(wr));
    finish_out("post");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/median3x3_row_engine.md
Name: median3x3_row_engine

Overview:
Downstream consumer of the row-window sequencer. Accepts one 3-row window (top, middle, bottom, edge rows already replicated upstream) through a valid/ready handshake. Sweeps the window column by column through a 3-stage pipelined 3x3 median network. Presents the filtered middle row as one wide word with a valid/ready handshake.

Parameters:
ROW, 512, pixels per row (window columns).
width, 8, bits per pixel, unsigned.
CW, 9, column-counter width; must satisfy 2^CW >= ROW.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  reset, asynchronous, active-low.
win_in  input  3*ROW*width  window; top row [3*ROW*width-1 : 2*ROW*width], middle next, bottom [ROW*width-1:0]; pixel i of a row at bits [i*width +: width].
in_valid  input  1  win_in valid.
in_ready  output  1  engine can accept a window.
row_out  output  ROW*width  filtered middle row; same pixel packing as win_in.
out_valid  output  1  row_out complete and stable.
out_ready  input  1  consumer takes row_out.
busy  output  1  high in SWEEP or DRAIN.
col  output  CW  current issue column (debug).

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RST).
- While RST=0:
  - State is IDLE.
  - Window registers, pipeline registers, row_out, col and drain counter are 0.
  - out_valid=0, busy=0, in_ready=0.
  - in_ready goes to 1 on the first edge after release.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, win_in is captured into internal top/mid/bot registers, col<=0, state<=SWEEP.
  - in_valid with in_ready=0 is ignored. Upstream holds the window.
- SWEEP:
  - Each cycle issues column c=col.
  - Left neighbour index = max(c-1,0). Right neighbour index = min(c+1,ROW-1). This is edge replication.
  - col increments. When col==ROW-1, state<=DRAIN and the 2-cycle drain counter is cleared.
- Pipeline (registered at each stage):
  - S1: sort each of the 3 columns (3 pixels each) into min/mid/max.
  - S2: A=max of the 3 mins, B=median of the 3 mids, C=min of the 3 maxes.
  - S3: median(A,B,C) written into row_out pixel slot c.
  - The column index travels with the data through the pipeline.
  - All compares are unsigned, width bits. No arithmetic widening.
- DRAIN: lasts exactly 2 cycles so the last column is written, then state<=DONE.
- DONE:
  - out_valid=1. row_out is stable.
  - On an edge with out_ready=1: out_valid<=0, state<=IDLE.
  - row_out keeps its value until overwritten by the next sweep.
- Latency: out_valid rises on edge ROW+3 counted from the accept edge (accept edge = 0). Throughput is one window per ROW+4 cycles minimum.
- busy=1 exactly in SWEEP and DRAIN. in_ready=1 only in IDLE. A new window cannot be accepted in the same cycle as the output handshake.
- row_out is partially updated during SWEEP/DRAIN. Consumers sample it only when out_valid=1.
- RST asserted mid-sweep or in DONE aborts immediately. Everything returns to reset values and the partial row is discarded.
- out_ready while out_valid=0 has no effect.
- in_valid toggling during SWEEP/DRAIN/DONE has no effect.

Test Plan:
- ROW=8, all pixels 8'h55 -> in_ready high in IDLE. out_valid rises on edge 11 after accept. row_out = all 8'h55. busy high for edges 1-10.
- ROW=8, middle row 10,200,10,200,10,200,10,200, top/bottom rows 10 -> every output pixel 10 (impulse noise removed).
- ROW=8, top row pixel i=i, middle row=i+8, bottom row=i+16 -> pixel 0 = median{0,0,1,8,8,9,16,16,17}=8. pixel 7 = median{6,7,7,14,15,15,22,23,23}=15. Pixels 1..6 = i+8. Checks edge clamping.
- Back-to-back windows with out_ready held 0 for 5 cycles after out_valid -> row_out and out_valid stable, in_ready stays 0. With out_ready=1: out_valid falls next edge, in_ready=1 next cycle, second window accepted.
- Assert RST at SWEEP col=4 -> out_valid=0, row_out=0, busy=0 immediately. After release a fresh window completes with correct results.
- Pixels 8'hFF and 8'h00 mixed (e.g. five 8'hFF, four 8'h00 per neighbourhood) -> median 8'hFF. This is an unsigned-compare check.
